// File: rtl/updown_sequencer.sv
// updown_sequencer: run-mode controller for a 4-bit up/down counter.
// Drives counter direction and advance-enable from the counter's own value,
// supporting continuous up/down, ping-pong between limits, and run-to-target.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; counter frozen
// S_RUN    | counter advancing under the latched mode
// S_PAUSED | run frozen while pause is high; direction held
// S_DONE   | single-cycle completion pulse, then back to S_IDLE
module updown_sequencer #(
   parameter int PASS_W = 8
) (
   input  logic              clock_div,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [1:0]        mode,
   input  logic [3:0]        low_limit,
   input  logic [3:0]        high_limit,
   input  logic [3:0]        target,
   input  logic [3:0]        count_in,
   output logic              up_down,
   output logic              cnt_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [PASS_W-1:0] pass_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [1:0]        MODE_UP     = 2'd0;
   localparam logic [1:0]        MODE_DOWN   = 2'd1;
   localparam logic [1:0]        MODE_PING   = 2'd2;
   localparam logic [1:0]        MODE_TARGET = 2'd3;
   localparam logic [PASS_W-1:0] PASS_MAX    = '1;

   state_t            r_state;
   logic              r_dir;
   logic              r_done;
   logic              r_err;
   logic [PASS_W-1:0] r_pass;
   logic [1:0]        r_mode;
   logic [3:0]        r_low;
   logic [3:0]        r_high;
   logic [3:0]        r_target;

   logic w_at_target;
   logic w_turn;
   logic w_wrap;
   logic w_pass_inc;
   logic w_limits_bad;
   logic w_start_dir;

   // Decode of counter position against the latched run parameters.
   always_comb begin
      w_at_target  = (count_in == r_target);
      // Ping-pong turnaround: heading up at the ceiling or down at the floor.
      w_turn       = (r_mode == MODE_PING) &&
                     (r_dir ? (count_in == r_high) : (count_in == r_low));
      w_wrap       = ((r_mode == MODE_UP)   && (count_in == 4'hF)) ||
                     ((r_mode == MODE_DOWN) && (count_in == 4'h0));
      w_pass_inc   = (w_turn || w_wrap) && (r_pass != PASS_MAX);
      w_limits_bad = (mode == MODE_PING) && (low_limit >= high_limit);
      case (mode)
         MODE_UP:   w_start_dir = 1'b1;
         MODE_DOWN: w_start_dir = 1'b0;
         // Below or at the floor climbs; at or above the ceiling descends;
         // strictly inside the window starts upward.
         MODE_PING: w_start_dir = (count_in <= low_limit)  ? 1'b1 :
                                  (count_in >= high_limit) ? 1'b0 : 1'b1;
         default:   w_start_dir = (target > count_in);
      endcase
   end

   // Counter control is combinational so it drops in the same cycle the
   // state leaves RUN (including asynchronous reset).
   always_comb begin
      cnt_en   = (r_state == S_RUN) && !((r_mode == MODE_TARGET) && w_at_target);
      up_down  = ((r_state == S_RUN) && w_turn) ? ~r_dir : r_dir;
      busy     = (r_state == S_RUN) || (r_state == S_PAUSED);
      done     = r_done;
      err      = r_err;
      pass_cnt = r_pass;
   end

   // Sequencer FSM with latched run parameters and pass counter.
   always_ff @(posedge clock_div or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_dir    <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_pass   <= '0;
         r_mode   <= '0;
         r_low    <= '0;
         r_high   <= '0;
         r_target <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  r_mode   <= mode;
                  r_low    <= low_limit;
                  r_high   <= high_limit;
                  r_target <= target;
                  r_pass   <= '0;
                  r_err    <= w_limits_bad;
                  if (!w_limits_bad) begin
                     r_dir   <= w_start_dir;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               // The counter steps on every RUN edge, so turnaround and pass
               // bookkeeping happen even on the edge that leaves RUN.
               if (w_turn) begin
                  r_dir <= ~r_dir;
               end
               if (w_pass_inc) begin
                  r_pass <= r_pass + 1'b1;
               end
               if (stop) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (pause) begin
                  r_state <= S_PAUSED;
               end else if ((r_mode == MODE_TARGET) && w_at_target) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_PAUSED: begin
               if (stop) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (!pause) begin
                  r_state <= S_RUN;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_updown_sequencer.sv
// Bench for updown_sequencer: the bench plays the 4-bit counter, a
// behavioural model predicts the sequencer outputs each cycle into a queue,
// and a monitor process pops and compares.
module tb_updown_sequencer;

   localparam int PASS_W   = 8;
   localparam int PASS_MAX = (1 << PASS_W) - 1;
   localparam int PH_IDLE   = 0;
   localparam int PH_RUN    = 1;
   localparam int PH_PAUSED = 2;
   localparam int PH_DONE   = 3;

   logic              clock_div  = 1'b0;
   logic              reset      = 1'b0;
   logic              start      = 1'b0;
   logic              stop       = 1'b0;
   logic              pause      = 1'b0;
   logic [1:0]        mode       = 2'd0;
   logic [3:0]        low_limit  = 4'd0;
   logic [3:0]        high_limit = 4'd0;
   logic [3:0]        target     = 4'd0;
   logic [3:0]        count_in   = 4'd0;
   logic              up_down;
   logic              cnt_en;
   logic              busy;
   logic              done;
   logic              err;
   logic [PASS_W-1:0] pass_cnt;

   updown_sequencer #(.PASS_W(PASS_W)) dut (
      .clock_div  (clock_div),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .mode       (mode),
      .low_limit  (low_limit),
      .high_limit (high_limit),
      .target     (target),
      .count_in   (count_in),
      .up_down    (up_down),
      .cnt_en     (cnt_en),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .pass_cnt   (pass_cnt)
   );

   always #5 clock_div = ~clock_div;

   typedef struct {
      logic              cnt_en;
      logic              up_down;
      logic              busy;
      logic              done;
      logic              err;
      logic [PASS_W-1:0] pass;
   } exp_t;

   exp_t sb_q[$];
   exp_t e_mon;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: run phase plus the quantities the rules talk about.
   int   m_phase = PH_IDLE;
   bit   m_dir   = 1'b1;
   bit   m_err   = 1'b0;
   int   m_pass  = 0;
   int   m_mode  = 0;
   int   m_lo    = 0;
   int   m_hi    = 0;
   int   m_tgt   = 0;
   logic [3:0] cnt_next = 4'd0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE; m_dir = 1'b1; m_err = 1'b0; m_pass = 0;
      m_mode = 0; m_lo = 0; m_hi = 0; m_tgt = 0;
   endtask

   function automatic exp_t model_out(input int c);
      exp_t e;
      bit running;
      running   = (m_phase == PH_RUN);
      e.busy    = running || (m_phase == PH_PAUSED);
      e.done    = (m_phase == PH_DONE);
      e.err     = m_err;
      e.pass    = m_pass[PASS_W-1:0];
      e.cnt_en  = running && !(m_mode == 3 && c == m_tgt);
      e.up_down = m_dir;
      if (running && m_mode == 2 && ((m_dir && c == m_hi) || (!m_dir && c == m_lo)))
         e.up_down = !m_dir;
      return e;
   endfunction

   task automatic bump_pass();
      if (m_pass < PASS_MAX) m_pass++;
   endtask

   task automatic model_step(input int c, input bit st, input bit sp, input bit pa,
                             input int md, input int lo, input int hi, input int tg);
      case (m_phase)
         PH_IDLE: begin
            if (st && !sp) begin
               m_mode = md; m_lo = lo; m_hi = hi; m_tgt = tg;
               m_pass = 0;
               m_err  = (md == 2) && (lo >= hi);
               if (!m_err) begin
                  m_phase = PH_RUN;
                  if (md == 0)      m_dir = 1'b1;
                  else if (md == 1) m_dir = 1'b0;
                  else if (md == 2) m_dir = (c < hi);
                  else              m_dir = (tg > c);
               end
            end
         end
         PH_RUN: begin
            if (m_mode == 2 && ((m_dir && c == m_hi) || (!m_dir && c == m_lo))) begin
               m_dir = !m_dir;
               bump_pass();
            end
            if ((m_mode == 0 && c == 15) || (m_mode == 1 && c == 0)) bump_pass();
            if (sp)                              m_phase = PH_DONE;
            else if (pa)                         m_phase = PH_PAUSED;
            else if (m_mode == 3 && c == m_tgt)  m_phase = PH_DONE;
         end
         PH_PAUSED: begin
            if (sp)       m_phase = PH_DONE;
            else if (!pa) m_phase = PH_RUN;
         end
         default: m_phase = PH_IDLE;
      endcase
   endtask

   // One clock cycle: present count and inputs, predict, advance model/counter.
   task automatic cycle(input bit st, input bit sp, input bit pa, input logic [1:0] md,
                        input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] tg);
      exp_t e;
      @(negedge clock_div);
      count_in = cnt_next;
      start = st; stop = sp; pause = pa;
      mode = md; low_limit = lo; high_limit = hi; target = tg;
      #1;
      e = model_out(int'(count_in));
      sb_q.push_back(e);
      model_step(int'(count_in), st, sp, pa, int'(md), int'(lo), int'(hi), int'(tg));
      if (cnt_en) cnt_next = up_down ? count_in + 4'd1 : count_in - 4'd1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
   endtask

   task automatic set_count(input logic [3:0] v);
      cnt_next = v;
   endtask

   task automatic do_reset_mid();
      @(negedge clock_div);
      count_in = cnt_next;
      #3;
      reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      #1;
      check("rst_mid_cnt_en", int'(cnt_en), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_pass", int'(pass_cnt), 0);
      check("rst_mid_up_down", int'(up_down), 1);
      model_reset();
      cnt_next = count_in;
      @(negedge clock_div);
      reset = 1'b1;
   endtask

   // Monitor: compares the DUT against the oldest prediction each cycle.
   always @(negedge clock_div) begin
      #2;
      if (sb_q.size() > 0) begin
         e_mon = sb_q.pop_front();
         n_tests++;
         if (cnt_en !== e_mon.cnt_en || up_down !== e_mon.up_down || busy !== e_mon.busy ||
             done !== e_mon.done || err !== e_mon.err || pass_cnt !== e_mon.pass) begin
            n_fail++;
            $display("FAIL sb t=%0t cnt=%0d: got en=%b ud=%b busy=%b done=%b err=%b pass=%0d, expected en=%b ud=%b busy=%b done=%b err=%b pass=%0d",
                     $time, count_in, cnt_en, up_down, busy, done, err, pass_cnt,
                     e_mon.cnt_en, e_mon.up_down, e_mon.busy, e_mon.done, e_mon.err, e_mon.pass);
         end
      end
   end

   // Watchdog: guarantees termination with a summary.
   initial begin
      #2000000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      bit entered;
      bit in_range;
      repeat (2) @(negedge clock_div);
      #1;
      check("rst_cnt_en", int'(cnt_en), 0);
      check("rst_up_down", int'(up_down), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_pass", int'(pass_cnt), 0);
      @(negedge clock_div);
      reset = 1'b1;

      // Reset mid-run in continuous-up mode at count 7.
      set_count(4'd5);
      cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
      idle(2);
      do_reset_mid();
      check("rst_mid_count", int'(count_in), 7);

      // Continuous up across the 15->0 wrap, then stop.
      set_count(4'd14);
      cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
      idle(4);
      cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
      idle(3);
      check("m0_pass_after", int'(pass_cnt), 1);

      // Ping-pong 3..6 from 0; count must stay inside once it gets there.
      set_count(4'd0);
      cycle(1'b1, 1'b0, 1'b0, 2'd2, 4'd3, 4'd6, 4'd0);
      entered = 1'b0;
      for (int k = 0; k < 25; k++) begin
         cycle(1'b0, 1'b0, 1'b0, 2'd1, 4'd9, 4'd1, 4'd0);
         if (count_in == 4'd3) entered = 1'b1;
         in_range = !(entered && (count_in < 4'd3 || count_in > 4'd6));
         check("m2_range", int'(in_range), 1);
      end
      cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
      idle(2);

      // Illegal ping-pong limits, then a legal start clears the flag.
      cycle(1'b1, 1'b0, 1'b0, 2'd2, 4'd5, 4'd5, 4'd0);
      idle(2);
      check("m2_err_set", int'(err), 1);
      cycle(1'b1, 1'b0, 1'b0, 2'd2, 4'd2, 4'd9, 4'd0);
      idle(5);
      check("m2_err_clr", int'(err), 0);
      cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
      idle(2);

      // Run down to target 2 from 9.
      set_count(4'd9);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd0, 4'd2);
      idle(12);
      check("m3_hold", int'(count_in), 2);

      // Run up to 12 from 4 with a pause holding the count at 8.
      set_count(4'd4);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd0, 4'd12);
      idle(3);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0, 4'd0);
      check("m3_paused_cnt", int'(count_in), 8);
      idle(10);
      check("m3_reach12", int'(count_in), 12);

      // Stop and pause together abort to DONE.
      set_count(4'd0);
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 4'd0, 4'd15);
      idle(2);
      cycle(1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 4'd0, 4'd0);
      idle(3);

      // Pass counter saturation in continuous down.
      set_count(4'd3);
      cycle(1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 4'd0, 4'd0);
      idle(16 * (PASS_MAX + 3));
      check("pass_sat", int'(pass_cnt), PASS_MAX);
      cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
      idle(3);

      // Randomised mix of starts, stops, pauses and run parameters.
      for (int i = 0; i < 3000; i++) begin
         if (m_phase == PH_IDLE && $urandom_range(0, 9) == 0)
            set_count(4'($urandom_range(0, 15)));
         cycle($urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0,
               $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
      end

      idle(2);
      #5;
      check("sb_drain", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
